operand_collector: RTL and testbench
====================================

Name: operand_collector

Overview:
- Parametrised operand assembly stage between the read-data return path and the execution unit.
- Collects NUM_SRC single-word source operands, then one WIDE_WORDS-word wide operand, all arriving serially on one valid/ready data stream.
- Captures the micro-instruction with the first word and presents one registered operand bundle on a valid/ready output handshake.
- Supports backpressure, a synchronous flush and selectable wide-operand word order.

Parameters:
DATA_W, 32, width of one read-data word and of each source operand
NUM_SRC, 2, number of single-word source operands (1..4)
WIDE_WORDS, 2, number of words in the wide operand (1..4)
MSW_FIRST, 1, 1: first wide word received is most significant; 0: least significant first
UINSTR_W, 16, micro-instruction width
OPCODE_W, 4, opcode width; opcode is uinstr bits [OPCODE_W-1:0]

Ports:
clk  input  1  clock, rising edge
arst_ni  input  1  asynchronous active-low reset
flush_i  input  1  synchronous abort of the bundle in progress
rd_data_valid_i  input  1  read word valid
rd_data_ready_o  output  1  collector can accept a word
rd_data_i  input  DATA_W  read word
uinstr_i  input  UINSTR_W  micro-instruction, sampled with the first word of a bundle
operand_o  output  NUM_SRC*DATA_W  source operands; operand k at bits [k*DATA_W +: DATA_W]
operand_wide_o  output  WIDE_WORDS*DATA_W  assembled wide operand
op_code_o  output  OPCODE_W  opcode of the held bundle
uinstr_o  output  UINSTR_W  micro-instruction of the held bundle
op_valid_o  output  1  bundle valid
op_ready_i  input  1  consumer accepts bundle
busy_o  output  1  at least one word of the current bundle accepted, bundle not yet complete

Behaviour:
- Reset (arst_ni low, asynchronous): state COLLECT, word counter 0. All outputs and internal registers 0, except rd_data_ready_o, which is 1 once out of reset.
- A word is accepted only on the cycle where rd_data_valid_i && rd_data_ready_o.
- rd_data_ready_o = (state == COLLECT). No word is accepted while a bundle is held.
- Word counter cnt counts 0 .. NUM_SRC+WIDE_WORDS-1.
  - cnt < NUM_SRC: the word is written to source slot cnt.
  - Otherwise it is wide word w = cnt-NUM_SRC.
    - MSW_FIRST=1: stored at slot WIDE_WORDS-1-w.
    - MSW_FIRST=0: stored at slot w.
- When cnt==0 is accepted, uinstr_i is latched. op_code_o is derived from the latched value, never from live uinstr_i.
- State COLLECT:
  - The accept at cnt == NUM_SRC+WIDE_WORDS-1 moves to HOLD.
  - op_valid_o goes to 1 on the next cycle, so latency from last word to valid is one cycle.
  - cnt then returns to 0.
- State HOLD:
  - op_valid_o=1. All bundle outputs are stable until the handshake.
  - op_valid_o && op_ready_i returns to COLLECT next cycle with op_valid_o=0 and rd_data_ready_o=1.
  - op_ready_i high earlier than HOLD has no effect.
- Output registers are not cleared after a handshake; they keep the last bundle until overwritten.
- Words are written directly into the output registers.
- busy_o = (state==COLLECT && cnt!=0).
- flush_i (synchronous, highest priority after reset):
  - In COLLECT: cnt returns to 0 and no word is accepted that cycle, even if valid. Partial data is discarded, and the next bundle restarts at source slot 0 with a fresh uinstr.
  - In HOLD: op_valid_o drops next cycle and the state returns to COLLECT.
- A valid word arriving together with flush_i is dropped, never stored.
- Reset asserted mid-bundle or mid-hold behaves identically to power-on reset; no partial state survives.
- No combinational path from rd_data_valid_i or op_ready_i to any output.

Test Plan:
- Default params: feed A=0x11111111, B=0x22222222, W0=0xAAAAAAAA, W1=0xBBBBBBBB back-to-back with uinstr_i=0x00A5 on the first word -> one cycle after W1: op_valid_o=1, operand_o={0x22222222,0x11111111}, operand_wide_o=0xAAAAAAAABBBBBBBB, op_code_o=0x5, uinstr_o=0x00A5.
- MSW_FIRST=0, same words -> operand_wide_o=0xBBBBBBBBAAAAAAAA.
- Gaps: rd_data_valid_i low 3 cycles between every word -> same bundle values; busy_o=1 from after A until the bundle completes.
- Backpressure: op_ready_i low 5 cycles during HOLD while rd_data_valid_i=1 with 0xDEADBEEF -> rd_data_ready_o=0, outputs unchanged, the word is not consumed. After op_ready_i=1: op_valid_o=0 next cycle, then 0xDEADBEEF is accepted as operand 0 of the next bundle.
- Flush after B with a valid word 0x33333333 presented in the same cycle -> word dropped, busy_o=0. The next 4 words form a clean bundle with a new uinstr. Flush during HOLD -> op_valid_o=0 next cycle.
- arst_ni pulsed low asynchronously mid-bundle (between clock edges) -> all outputs 0 immediately, cnt=0. The next full bundle is correct.

Source files
------------

// File: rtl/operand_collector.sv
// Operand collector: gathers NUM_SRC source words and a WIDE_WORDS-word wide operand from one
// serial read-data stream and presents them as a single registered bundle.
module operand_collector #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned WIDE_WORDS = 2,
  parameter int unsigned MSW_FIRST  = 1,
  parameter int unsigned UINSTR_W   = 16,
  parameter int unsigned OPCODE_W   = 4
) (
  input  logic                           clk,
  input  logic                           arst_ni,
  input  logic                           flush_i,
  input  logic                           rd_data_valid_i,
  output logic                           rd_data_ready_o,
  input  logic [DATA_W-1:0]              rd_data_i,
  input  logic [UINSTR_W-1:0]            uinstr_i,
  output logic [NUM_SRC*DATA_W-1:0]      operand_o,
  output logic [WIDE_WORDS*DATA_W-1:0]   operand_wide_o,
  output logic [OPCODE_W-1:0]            op_code_o,
  output logic [UINSTR_W-1:0]            uinstr_o,
  output logic                           op_valid_o,
  input  logic                           op_ready_i,
  output logic                           busy_o
);

  localparam int unsigned Total = NUM_SRC + WIDE_WORDS;
  localparam int unsigned CntW  = (Total > 1) ? $clog2(Total) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Total - 1);

  typedef enum logic {StCollect, StHold} state_e;

  state_e                               state_q, state_d;
  logic [CntW-1:0]                      cnt_q, cnt_d;
  logic [NUM_SRC-1:0][DATA_W-1:0]       src_q, src_d;
  logic [WIDE_WORDS-1:0][DATA_W-1:0]    wide_q, wide_d;
  logic [UINSTR_W-1:0]                  uinstr_q, uinstr_d;
  logic                                 accept;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    src_d    = src_q;
    wide_d   = wide_q;
    uinstr_d = uinstr_q;
    // A word presented together with flush is dropped.
    accept   = rd_data_valid_i && (state_q == StCollect) && !flush_i;

    unique case (state_q)
      StCollect: begin
        if (flush_i) begin
          cnt_d = '0;
        end else if (accept) begin
          if (cnt_q == CntLast) begin
            state_d = StHold;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StHold: begin
        if (flush_i || op_ready_i) state_d = StCollect;
      end
      default: state_d = StCollect;
    endcase

    if (accept) begin
      if (cnt_q == '0) uinstr_d = uinstr_i;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
        if (cnt_q == CntW'(k)) src_d[k] = rd_data_i;
      end
      // Slot s receives wide word w, where w depends on the configured arrival order.
      for (int unsigned s = 0; s < WIDE_WORDS; s++) begin
        if (cnt_q == CntW'(NUM_SRC + ((MSW_FIRST != 0) ? (WIDE_WORDS - 1 - s) : s))) begin
          wide_d[s] = rd_data_i;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= StCollect;
      cnt_q    <= '0;
      src_q    <= '0;
      wide_q   <= '0;
      uinstr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      src_q    <= src_d;
      wide_q   <= wide_d;
      uinstr_q <= uinstr_d;
    end
  end

  assign rd_data_ready_o = (state_q == StCollect);
  assign op_valid_o      = (state_q == StHold);
  assign busy_o          = (state_q == StCollect) && (cnt_q != '0);
  assign operand_o       = src_q;
  assign operand_wide_o  = wide_q;
  assign uinstr_o        = uinstr_q;
  assign op_code_o       = uinstr_q[OPCODE_W-1:0];

endmodule

// File: tb/tb_operand_collector.sv
// Scoreboard bench for operand_collector: a default-order instance plus an LSW-first instance.
module tb_operand_collector;

  logic        clk = 1'b0;
  logic        arst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        rd_data_valid_i = 1'b0;
  logic [31:0] rd_data_i = '0;
  logic [15:0] uinstr_i = '0;
  logic        op_ready_i = 1'b0;

  logic        rd_data_ready_o, op_valid_o, busy_o;
  logic [63:0] operand_o, operand_wide_o;
  logic [3:0]  op_code_o;
  logic [15:0] uinstr_o;

  logic        l_ready, l_valid, l_busy;
  logic [63:0] l_operand, l_wide;
  logic [3:0]  l_opcode;
  logic [15:0] l_uinstr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] operand;
    logic [63:0] wide_msw;
    logic [63:0] wide_lsw;
    logic [3:0]  opcode;
    logic [15:0] uinstr;
  } bundle_t;

  bundle_t exp_q[$];
  bundle_t cur;
  logic    prev_valid = 1'b0;

  always #5 clk = ~clk;

  operand_collector #(.MSW_FIRST(1)) u_dut (
    .clk(clk), .arst_ni(arst_ni), .flush_i(flush_i), .rd_data_valid_i(rd_data_valid_i),
    .rd_data_ready_o(rd_data_ready_o), .rd_data_i(rd_data_i), .uinstr_i(uinstr_i),
    .operand_o(operand_o), .operand_wide_o(operand_wide_o), .op_code_o(op_code_o),
    .uinstr_o(uinstr_o), .op_valid_o(op_valid_o), .op_ready_i(op_ready_i), .busy_o(busy_o)
  );

  operand_collector #(.MSW_FIRST(0)) u_dut_lsw (
    .clk(clk), .arst_ni(arst_ni), .flush_i(flush_i), .rd_data_valid_i(rd_data_valid_i),
    .rd_data_ready_o(l_ready), .rd_data_i(rd_data_i), .uinstr_i(uinstr_i),
    .operand_o(l_operand), .operand_wide_o(l_wide), .op_code_o(l_opcode),
    .uinstr_o(l_uinstr), .op_valid_o(l_valid), .op_ready_i(op_ready_i), .busy_o(l_busy)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: a new bundle pops the scoreboard; a held bundle must stay equal to it.
  always @(negedge clk) begin
    if (op_valid_o) begin
      if (!prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bundle: got operand %h expected no bundle", operand_o);
        end else begin
          cur = exp_q.pop_front();
        end
      end
      check("operand", operand_o, cur.operand);
      check("wide_msw_first", operand_wide_o, cur.wide_msw);
      check("wide_lsw_first", l_wide, cur.wide_lsw);
      check("op_code", {60'd0, op_code_o}, {60'd0, cur.opcode});
      check("uinstr", {48'd0, uinstr_o}, {48'd0, cur.uinstr});
      check("lsw_valid", {63'd0, l_valid}, 64'd1);
    end
    prev_valid <= op_valid_o;
  end

  task automatic push(input logic [63:0] op, input logic [63:0] wm, input logic [63:0] wl,
                      input logic [3:0] oc, input logic [15:0] ui);
    bundle_t b;
    b.operand = op; b.wide_msw = wm; b.wide_lsw = wl; b.opcode = oc; b.uinstr = ui;
    exp_q.push_back(b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word, wait (bounded) for acceptance, then drop valid.
  task automatic send(input logic [31:0] d, input logic [15:0] ui);
    bit done = 1'b0;
    rd_data_valid_i = 1'b1;
    rd_data_i = d;
    uinstr_i = ui;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (rd_data_ready_o) done = 1'b1;
      tick();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept for %h expected accept within 50 cycles", d);
    end
    rd_data_valid_i = 1'b0;
  endtask

  task automatic expect_now(input string name, input logic got, input logic exp);
    @(negedge clk);
    check(name, {63'd0, got}, {63'd0, exp});
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_valid", {63'd0, op_valid_o}, 64'd0);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_operand", operand_o, 64'd0);
    check("rst_wide", operand_wide_o, 64'd0);
    check("rst_uinstr", {44'd0, op_code_o, uinstr_o}, 64'd0);
    tick();
    arst_ni = 1'b1;
    expect_now("rst_ready", rd_data_ready_o, 1'b1);
    tick();

    // Back-to-back bundle, consumer ready early
    op_ready_i = 1'b1;
    push(64'h22222222_11111111, 64'hAAAAAAAA_BBBBBBBB, 64'hBBBBBBBB_AAAAAAAA, 4'h5, 16'h00A5);
    send(32'h11111111, 16'h00A5);
    send(32'h22222222, 16'hFFFF);
    send(32'hAAAAAAAA, 16'hFFFF);
    send(32'hBBBBBBBB, 16'hFFFF);
    expect_now("latency_valid", op_valid_o, 1'b1);
    check("hold_ready", {63'd0, rd_data_ready_o}, 64'd0);
    tick();
    expect_now("handshake_valid", op_valid_o, 1'b0);
    check("handshake_ready", {63'd0, rd_data_ready_o}, 64'd1);
    op_ready_i = 1'b0;
    tick();

    // Gaps of three idle cycles between words
    push(64'h22222222_11111111, 64'hAAAAAAAA_BBBBBBBB, 64'hBBBBBBBB_AAAAAAAA, 4'h7, 16'h1237);
    check("idle_busy", {63'd0, busy_o}, 64'd0);
    send(32'h11111111, 16'h1237);
    for (int i = 0; i < 3; i++) begin expect_now("gap_busy", busy_o, 1'b1); tick(); end
    send(32'h22222222, 16'h0000);
    for (int i = 0; i < 3; i++) begin expect_now("gap_busy", busy_o, 1'b1); tick(); end
    send(32'hAAAAAAAA, 16'h0000);
    for (int i = 0; i < 3; i++) begin expect_now("gap_busy", busy_o, 1'b1); tick(); end
    send(32'hBBBBBBBB, 16'h0000);
    expect_now("gap_done_busy", busy_o, 1'b0);
    check("gap_valid", {63'd0, op_valid_o}, 64'd1);
    tick();

    // Backpressure: word waits while a bundle is held
    push(64'h44444444_DEADBEEF, 64'h55555555_66666666, 64'h66666666_55555555, 4'h3, 16'h00C3);
    rd_data_valid_i = 1'b1;
    rd_data_i = 32'hDEADBEEF;
    uinstr_i = 16'h00C3;
    for (int i = 0; i < 5; i++) begin expect_now("bp_ready", rd_data_ready_o, 1'b0); tick(); end
    op_ready_i = 1'b1;
    tick();
    op_ready_i = 1'b0;
    expect_now("bp_valid_drop", op_valid_o, 1'b0);
    check("bp_ready_back", {63'd0, rd_data_ready_o}, 64'd1);
    check("bp_busy_before", {63'd0, busy_o}, 64'd0);
    tick();
    rd_data_valid_i = 1'b0;
    expect_now("bp_busy_after", busy_o, 1'b1);
    tick();
    send(32'h44444444, 16'h0000);
    send(32'h55555555, 16'h0000);
    send(32'h66666666, 16'h0000);
    expect_now("bp_bundle_valid", op_valid_o, 1'b1);
    op_ready_i = 1'b1;
    tick();
    op_ready_i = 1'b0;

    // Flush mid-bundle with a valid word in the same cycle
    send(32'h77777777, 16'h0011);
    send(32'h88888888, 16'h0000);
    rd_data_valid_i = 1'b1;
    rd_data_i = 32'h33333333;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    rd_data_valid_i = 1'b0;
    expect_now("flush_busy", busy_o, 1'b0);
    tick();
    push(64'h9ABCDEF0_12345678, 64'h0F0F0F0F_F0F0F0F0, 64'hF0F0F0F0_0F0F0F0F, 4'h9, 16'h00E9);
    send(32'h12345678, 16'h00E9);
    send(32'h9ABCDEF0, 16'h0000);
    send(32'h0F0F0F0F, 16'h0000);
    send(32'hF0F0F0F0, 16'h0000);
    expect_now("flush_bundle_valid", op_valid_o, 1'b1);
    tick();
    // Flush during hold
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    expect_now("hold_flush_valid", op_valid_o, 1'b0);
    check("hold_flush_ready", {63'd0, rd_data_ready_o}, 64'd1);
    tick();

    // Asynchronous reset between clock edges, mid-bundle
    send(32'h00000001, 16'h0FFF);
    send(32'h00000002, 16'h0000);
    #2 arst_ni = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy_o}, 64'd0);
    check("arst_valid", {63'd0, op_valid_o}, 64'd0);
    check("arst_operand", operand_o, 64'd0);
    check("arst_wide", operand_wide_o, 64'd0);
    check("arst_uinstr", {44'd0, op_code_o, uinstr_o}, 64'd0);
    tick();
    arst_ni = 1'b1;
    tick();
    push(64'h0BADC0DE_CAFEF00D, 64'h01234567_89ABCDEF, 64'h89ABCDEF_01234567, 4'h2, 16'h0042);
    send(32'hCAFEF00D, 16'h0042);
    send(32'h0BADC0DE, 16'h0000);
    send(32'h01234567, 16'h0000);
    send(32'h89ABCDEF, 16'h0000);
    expect_now("arst_bundle_valid", op_valid_o, 1'b1);
    op_ready_i = 1'b1;
    tick();
    op_ready_i = 1'b0;
    tick();
    tick();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
